// File: rtl/xdisplay_ctrl_pkg.sv
// Shared definitions for the 4-digit seven-segment display controller:
// data field layout, digit count, register addresses and scan states.
package xdisplay_ctrl_pkg;

    localparam int DATA_W     = 8;
    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 6;

    // Field positions inside a digit register and inside data_in
    localparam int HEX_LSB   = 0;
    localparam int HEX_MSB   = 3;
    localparam int BLANK_BIT = 4;
    localparam int DP_BIT    = 5;

    localparam logic [7:0] DISPLAY0 = 8'h10;
    localparam logic [7:0] DISPLAY1 = 8'h11;
    localparam logic [7:0] DISPLAY2 = 8'h12;
    localparam logic [7:0] DISPLAY3 = 8'h13;

    localparam logic [DIGIT_W-1:0] DIGIT_RESET = 6'b010000;
    localparam logic [3:0]         AN_OFF      = 4'b1111;
    localparam logic [6:0]         SEG_OFF     = 7'h7F;

    typedef enum logic {
        SCAN_GAP   = 1'b0,
        SCAN_DRIVE = 1'b1
    } scan_state_e;

endpackage

// File: rtl/xseg_decoder.sv
// Combinational hex to active-low seven-segment decoder, output order {g,f,e,d,c,b,a}.
module xseg_decoder (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Hex digit lookup table
    always_comb begin
        case (hex)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/xdisplay_ctrl.sv
// Four-digit multiplexed seven-segment display controller with per-digit
// write strobes, anti-ghosting gap at the start of every slot and registered outputs.
module xdisplay_ctrl
    import xdisplay_ctrl_pkg::*;
#(
    parameter int REFRESH_W  = 16,
    parameter int GAP_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_DIGITS-1:0] display_sel,
    input  logic [DATA_W-1:0]     data_in,
    output logic [3:0]            an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam logic [REFRESH_W-1:0] GAP_END   = REFRESH_W'(GAP_CYCLES);
    localparam logic [REFRESH_W-1:0] PRESC_MAX = {REFRESH_W{1'b1}};
    localparam logic [REFRESH_W-1:0] PRESC_ONE = REFRESH_W'(1);

    logic [DIGIT_W-1:0]   digit_r [NUM_DIGITS];
    logic [REFRESH_W-1:0] presc_r;
    logic [1:0]           idx_r;
    logic [DIGIT_W-1:0]   cur_digit_s;
    logic [6:0]           dec_seg_s;
    scan_state_e          state_s;
    logic                 unused_data_s;

    // Bits above the digit field carry no meaning for this block
    assign unused_data_s = ^data_in[DATA_W-1:DIGIT_W];

    // Select the digit being scanned and derive the slot phase from the prescaler
    always_comb begin
        cur_digit_s = digit_r[idx_r];
        if (presc_r < GAP_END) begin
            state_s = SCAN_GAP;
        end else begin
            state_s = SCAN_DRIVE;
        end
    end

    xseg_decoder u_seg_decoder (
        .hex (cur_digit_s[HEX_MSB:HEX_LSB]),
        .seg (dec_seg_s)
    );

    // Digit storage, scan counters and registered display outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= {REFRESH_W{1'b0}};
            idx_r   <= 2'd0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_r[i] <= DIGIT_RESET;
            end
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            presc_r <= presc_r + PRESC_ONE;
            if (presc_r == PRESC_MAX) begin
                idx_r <= idx_r + 2'd1;
            end else begin
                idx_r <= idx_r;
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (display_sel[i]) begin
                    digit_r[i] <= data_in[DIGIT_W-1:0];
                end else begin
                    digit_r[i] <= digit_r[i];
                end
            end
            // Outputs reflect the pre-edge index, prescaler and digit contents
            case (state_s)
                SCAN_GAP: begin
                    an  <= AN_OFF;
                    seg <= SEG_OFF;
                    dp  <= 1'b1;
                end
                SCAN_DRIVE: begin
                    an <= ~(4'b0001 << idx_r);
                    if (cur_digit_s[BLANK_BIT]) begin
                        seg <= SEG_OFF;
                        dp  <= 1'b1;
                    end else begin
                        seg <= dec_seg_s;
                        dp  <= ~cur_digit_s[DP_BIT];
                    end
                end
                default: begin
                    an  <= AN_OFF;
                    seg <= SEG_OFF;
                    dp  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/xdisplay_ctrl.md
XDISPLAY_CTRL -- requirements
Module: xdisplay_ctrl

Interface
REQ-001 Parameter: REFRESH_W, 16, prescaler width; each digit slot lasts 2^REFRESH_W clk cycles.
REQ-002 Parameter: GAP_CYCLES, 64, cycles at the start of each slot with all anodes off (anti-ghosting); SHALL be < 2^REFRESH_W.
REQ-003 clk  input  1  system clock; one clock domain, all logic on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 display_sel  input  4  per-digit write strobe, one bit per digit 0..3, already qualified by wr_en upstream.
REQ-006 data_in  input  `DATA_W  write data; bits [3:0] hex value, bit [4] blank, bit [5] decimal point on; other bits ignored.
REQ-007 an  output  4  digit anodes, active-low, registered.
REQ-008 seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-009 dp  output  1  decimal point, active-low, registered.

Function
REQ-010 Four 6-bit digit registers {dp_on, blank, hex[3:0]}. On a clk edge with display_sel[i]=1, digit i SHALL load data_in[5:0].
REQ-011 Multiple display_sel bits high in one cycle SHALL write every selected digit with the same value; display_sel=0 leaves all registers unchanged.
REQ-012 Prescaler counts 0 .. 2^REFRESH_W-1 and wraps to 0; on wrap the 2-bit digit index advances 0->1->2->3->0.
REQ-013 Scan states per slot: GAP (prescaler < GAP_CYCLES) -> DRIVE (remaining cycles) -> GAP of next digit; no other states.
REQ-014 GAP: an=4'b1111, seg=7'h7F, dp=1.
REQ-015 DRIVE, digit i not blanked: an = all ones except bit i = 0; seg = hex decode of digit i; dp = ~dp_on.
REQ-016 DRIVE, digit i blanked: an bit i = 0, seg=7'h7F, dp=1.
REQ-017 Hex decode (active-low, {g..a}): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-018 Outputs SHALL be registered from current index, prescaler state and digit register contents: one cycle latency.
REQ-019 A write to the currently driven digit SHALL appear on seg/dp on the second rising edge after the write edge (register update, then output register).
REQ-020 A write coinciding with the prescaler wrap SHALL still be stored; the index advances normally.
REQ-021 No combinational path from display_sel/data_in to outputs.

Reset
REQ-022 rst=1 at a clk edge: all digit registers = 6'b010000 (blanked, hex 0, dp off), prescaler=0, index=0, an=4'b1111, seg=7'h7F, dp=1.
REQ-023 rst has priority over display_sel writes in the same cycle.
REQ-024 rst asserted mid-scan or mid-slot SHALL restart at digit 0, GAP state, prescaler 0, on the next edge.

Structure
REQ-025 Data field positions (HEX, BLANK, DP) and the digit count SHALL be defined in xdefs.vh beside DATA_W and the DISPLAY0..3 addresses.
REQ-026 Hex-to-segment table SHALL be a purely combinational sub-module xseg_decoder (4-bit in, 7-bit active-low out), instantiated once on the muxed digit.
REQ-027 Block is driven directly by the external address decoder's display_sel outputs; no bus handshake.

Verification (REFRESH_W=4, GAP_CYCLES=2 unless stated)
REQ-028 Reset -> an=1111, seg=1111111, dp=1 on the cycle after; digits stay blank for a full 64-cycle scan.
REQ-029 display_sel=0001, data_in=0x03 -> in digit-0 DRIVE an=1110, seg=0110000, dp=1; digits 1..3 show blank (seg=1111111).
REQ-030 display_sel=1111, data_in=0x28 -> every DRIVE phase shows seg=0000000, dp=0; sequence an 1110,1101,1011,0111 with 16-cycle slots, first 2 cycles of each 1111.
REQ-031 Digit 2 showing 0xF, write 0x1F to digit 2 during its DRIVE -> seg changes 0001110 to 1111111 exactly two edges after the write; an bit 2 stays 0.
REQ-032 Sweep hex 0..F into digit 3 -> each seg value matches REQ-017.
REQ-033 rst pulsed one cycle in the middle of digit 2 DRIVE, simultaneous with a write -> write discarded, outputs 1111/1111111/1 next cycle, scan restarts at digit 0 after GAP.
